// File: rtl/pipe_hazard_unit.sv
// Hazard/forwarding controller for the 5-stage core: scoreboard of in-flight
// destinations, decode stall, branch flush, EX bubble and forwarding selects.
module pipe_hazard_unit #(
    parameter int REG_AW      = 5,
    parameter int DEPTH       = 3,
    parameter int LOAD_LAT    = 1,
    parameter int FWD_EN      = 1,
    parameter int ZERO_REG_EN = 1,
    parameter int CNT_W       = 16,
    localparam int SEL_W      = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rn,
    input  logic [REG_AW-1:0] id_rm,
    input  logic              id_use_rn,
    input  logic              id_use_rm,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_reg_write,
    input  logic              id_is_load,
    input  logic              br_taken,
    output logic              stall,
    output logic              flush_id,
    output logic              bubble_ex,
    output logic [SEL_W-1:0]  fwd_sel_a,
    output logic [SEL_W-1:0]  fwd_sel_b,
    output logic [CNT_W-1:0]  stall_cnt
);

    logic [DEPTH-1:0]  r_vld;
    logic [DEPTH-1:0]  r_wr;
    logic [DEPTH-1:0]  r_ld;
    logic [REG_AW-1:0] r_rd [DEPTH];
    logic [SEL_W-1:0]  r_fwd_sel_a;
    logic [SEL_W-1:0]  r_fwd_sel_b;
    logic [CNT_W-1:0]  r_stall_cnt;

    logic              w_src_ok_a;
    logic              w_src_ok_b;
    logic              w_hit_a;
    logic              w_hit_b;
    logic              w_ld_a;
    logic              w_ld_b;
    logic [SEL_W-1:0]  w_idx_a;
    logic [SEL_W-1:0]  w_idx_b;
    logic              w_haz_a;
    logic              w_haz_b;
    logic              w_stall;
    logic              w_issue;
    logic [SEL_W-1:0]  w_nxt_sel_a;
    logic [SEL_W-1:0]  w_nxt_sel_b;

    // Youngest-match search: scanning oldest to youngest lets the lowest index win.
    always_comb begin
        w_src_ok_a = id_use_rn & ((ZERO_REG_EN == 0) | (id_rn != {REG_AW{1'b0}}));
        w_src_ok_b = id_use_rm & ((ZERO_REG_EN == 0) | (id_rm != {REG_AW{1'b0}}));
        w_hit_a = 1'b0;
        w_hit_b = 1'b0;
        w_ld_a  = 1'b0;
        w_ld_b  = 1'b0;
        w_idx_a = {SEL_W{1'b0}};
        w_idx_b = {SEL_W{1'b0}};
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (w_src_ok_a && r_vld[i] && r_wr[i] && (r_rd[i] == id_rn)) begin
                w_hit_a = 1'b1;
                w_ld_a  = r_ld[i];
                w_idx_a = SEL_W'(i);
            end else begin
                w_hit_a = w_hit_a;
            end
            if (w_src_ok_b && r_vld[i] && r_wr[i] && (r_rd[i] == id_rm)) begin
                w_hit_b = 1'b1;
                w_ld_b  = r_ld[i];
                w_idx_b = SEL_W'(i);
            end else begin
                w_hit_b = w_hit_b;
            end
        end
    end

    // A WB-stage match must stall because the register file does not write through.
    always_comb begin
        w_haz_a = w_hit_a & ((FWD_EN == 0) | (w_ld_a & (int'(w_idx_a) < LOAD_LAT)) |
                             (w_idx_a == SEL_W'(DEPTH - 1)));
        w_haz_b = w_hit_b & ((FWD_EN == 0) | (w_ld_b & (int'(w_idx_b) < LOAD_LAT)) |
                             (w_idx_b == SEL_W'(DEPTH - 1)));
        w_stall = (w_haz_a | w_haz_b) & id_valid & ~br_taken;
        w_issue = id_valid & ~w_stall & ~br_taken;
        w_nxt_sel_a = (w_issue & w_hit_a & ~w_haz_a) ? (w_idx_a + SEL_W'(1)) : {SEL_W{1'b0}};
        w_nxt_sel_b = (w_issue & w_hit_b & ~w_haz_b) ? (w_idx_b + SEL_W'(1)) : {SEL_W{1'b0}};
    end

    // Scoreboard shift, forwarding-select registers and saturating stall counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_vld       <= {DEPTH{1'b0}};
            r_wr        <= {DEPTH{1'b0}};
            r_ld        <= {DEPTH{1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                r_rd[i] <= {REG_AW{1'b0}};
            end
            r_fwd_sel_a <= {SEL_W{1'b0}};
            r_fwd_sel_b <= {SEL_W{1'b0}};
            r_stall_cnt <= {CNT_W{1'b0}};
        end else begin
            for (int i = DEPTH - 1; i > 0; i--) begin
                r_vld[i] <= r_vld[i-1];
                r_wr[i]  <= r_wr[i-1];
                r_ld[i]  <= r_ld[i-1];
                r_rd[i]  <= r_rd[i-1];
            end
            r_vld[0]    <= w_issue;
            r_wr[0]     <= w_issue & id_reg_write;
            r_ld[0]     <= w_issue & id_is_load;
            r_rd[0]     <= id_rd;
            r_fwd_sel_a <= w_nxt_sel_a;
            r_fwd_sel_b <= w_nxt_sel_b;
            if (w_stall && (r_stall_cnt != {CNT_W{1'b1}})) begin
                r_stall_cnt <= r_stall_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
                r_stall_cnt <= r_stall_cnt;
            end
        end
    end

    assign stall     = w_stall;
    assign flush_id  = br_taken;
    assign bubble_ex = w_stall | br_taken;
    assign fwd_sel_a = r_fwd_sel_a;
    assign fwd_sel_b = r_fwd_sel_b;
    assign stall_cnt = r_stall_cnt;

endmodule
